paddle_bank: RTL and testbench
==============================

Name: paddle_bank

Overview:
- Parametrised, multi-channel player-input front end. Replaces the per-player chain of debounce, rot_encoder and paddle instances with one block.
- Each channel takes one quadrature encoder pair. It debounces the pair, decodes it with full 4x quadrature, and keeps a bounded paddle position.
- Outputs per channel: a registered position and a FIELD-bit occupancy mask. The mask feeds game, screen and vga.
- Adds per-channel quadrature-error detection, configurable steps per detent, and a synchronous recentre.

Parameters:
- CHANNELS, 2, number of encoder/paddle channels (1..8).
- HIST_LEN, 16, debounce window in clk cycles (2..32).
- FIELD, 32, playfield height in rows; width of each paddle mask.
- PADDLE_LEN, 8, paddle height in rows (1..FIELD-1).
- QUARTERS_PER_STEP, 4, valid quadrature transitions needed per one-row move (1, 2 or 4).
- POS_W, 5, position width; must satisfy 2**POS_W >= FIELD.

Ports:
- clk  in  1  block clock.
- reset  in  1  asynchronous, active-low reset.
- center  in  1  synchronous recentre of all channels; also clears errors.
- quad_a  in  CHANNELS  encoder phase A, bit i = channel i, asynchronous to clk.
- quad_b  in  CHANNELS  encoder phase B, bit i = channel i.
- paddle_pos  out  CHANNELS*POS_W  top row of each paddle, channel i at [i*POS_W +: POS_W].
- paddle_mask  out  CHANNELS*FIELD  rows pos..pos+PADDLE_LEN-1 set, channel i at [i*FIELD +: FIELD].
- step_strobe  out  CHANNELS  one-cycle pulse on the cycle a channel's position changes.
- quad_err  out  CHANNELS  sticky illegal-transition flag.

Behaviour:
- Reset (reset=0, async):
  - paddle_pos = CTR = (FIELD-PADDLE_LEN)/2 (integer division).
  - paddle_mask = mask(CTR); step_strobe = 0; quad_err = 0.
  - Debounce histories and debounced outputs = 0; accumulators = 0; decoder valid flags = 0.
- Debounce, per input bit:
  - HIST_LEN-bit shift register samples the raw input every clk (2-flop synchroniser ahead of it).
  - Debounced output goes to 1 when the history is all ones, to 0 when all zeros; otherwise it holds.
- Decoder, per channel, in state IDLE until primed:
  - Primed once both histories have been uniform simultaneously; at that point prev <= {a_db, b_db} and the state becomes RUN. No counting happens on the priming cycle.
  - In RUN, {a,b} is compared with prev every cycle:
    - Gray-forward (00>01>11>10>00): acc+1.
    - Gray-reverse: acc-1.
    - Equal: no change.
    - Both bits changed: quad_err set, acc unchanged.
  - prev is always updated.
- Accumulator:
  - Signed, range ±QUARTERS_PER_STEP.
  - Reaching +QUARTERS_PER_STEP requests up (pos+1) and clears acc.
  - Reaching -QUARTERS_PER_STEP requests down (pos-1) and clears acc.
- Position:
  - Updates on the edge after the transition is decoded.
  - Total latency from the raw edge is 2 (sync) + HIST_LEN + 1 cycles.
  - Saturates at 0 and at FIELD-PADDLE_LEN; a request at a limit is dropped with no strobe.
  - paddle_mask is registered and updated on the same edge as paddle_pos.
  - step_strobe is high for exactly that cycle.
- center=1:
  - All pos = CTR, acc = 0, quad_err = 0, step_strobe = 0.
  - Takes priority over a same-cycle step or error.
  - prev and valid flags are unaffected.
- Channels are fully independent; simultaneous steps on different channels all take effect.

Optional Feature:
- Macro: PADDLE_WRAP_EN.
- Defined:
  - pos wraps modulo FIELD: 0 down -> FIELD-1, FIELD-1 up -> 0.
  - The mask wraps cyclically (bits above FIELD-1 fold into bit 0 upward).
  - step_strobe fires on every step.
- Undefined: saturating behaviour as described in Behaviour.

Test Plan (CHANNELS=2, FIELD=32, PADDLE_LEN=8, HIST_LEN=4, QUARTERS_PER_STEP=4):
- Release reset with inputs held 00 for 10 cycles -> pos0 = pos1 = 12, mask0 = 0x000FF000, quad_err = 00, no strobe.
- Ch0 driven 00>01>11>10>00, each phase held 8 cycles -> exactly one strobe; pos0 = 13, mask0 = 0x001FE000; pos1 stays 12.
- Ch0 input chattering 1-0-1 at 1-cycle intervals, then 00 held -> no position change, no strobe, no error.
- 14 reverse detents on ch1 -> pos1 = 0 after 12 detents; detents 13 and 14 give no strobe, pos1 stays 0 (wrap build: pos1 = 30, mask1 = 0xC000003F).
- Ch0 jumps 00 -> 11 -> quad_err[0] = 1 and persists; pos0 unchanged; pulse center -> pos0 = 12, quad_err = 00.
- Assert reset mid-sequence after 2 forward quarters -> outputs return to reset values immediately; a fresh full detent afterwards moves pos by exactly 1.

Source files
------------

// File: rtl/paddle_bank.sv
// Multi-channel quadrature paddle front end: debounce, 4x decode, bounded position.
// Define PADDLE_WRAP_EN for modulo-FIELD position and cyclic mask.
module paddle_bank #(
  parameter int CHANNELS          = 2,
  parameter int HIST_LEN          = 16,
  parameter int FIELD             = 32,
  parameter int PADDLE_LEN        = 8,
  parameter int QUARTERS_PER_STEP = 4,
  parameter int POS_W             = 5
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic                      center,
  input  logic [CHANNELS-1:0]       quad_a,
  input  logic [CHANNELS-1:0]       quad_b,
  output logic [CHANNELS*POS_W-1:0] paddle_pos,
  output logic [CHANNELS*FIELD-1:0] paddle_mask,
  output logic [CHANNELS-1:0]       step_strobe,
  output logic [CHANNELS-1:0]       quad_err
);

  localparam logic [POS_W-1:0] CTR_P =
    POS_W'((FIELD - PADDLE_LEN) / 2);
  localparam logic signed [3:0] QP = 4'(QUARTERS_PER_STEP);
  localparam logic signed [3:0] QN = -QP;

  function automatic logic [FIELD-1:0] mask_of(
    input logic [POS_W-1:0] p
  );
    logic [FIELD-1:0] m;
    m = '0;
    for (int r = 0; r < FIELD; r++) begin
      if (((r + FIELD - int'(p)) % FIELD) < PADDLE_LEN)
        m[r] = 1'b1;
    end
    return m;
  endfunction

  // Gray phase index: 00->0, 01->1, 11->2, 10->3
  function automatic logic [1:0] gidx(input logic [1:0] ab);
    logic [1:0] g;
    case (ab)
      2'b00:   g = 2'd0;
      2'b01:   g = 2'd1;
      2'b11:   g = 2'd2;
      default: g = 2'd3;
    endcase
    return g;
  endfunction

  for (genvar i = 0; i < CHANNELS; i++) begin : g_ch
    logic [1:0]          sa, sb;
    logic [HIST_LEN-1:0] ha, hb;
    logic                da, db, da_n, db_n;
    logic                a_uni, b_uni;
    logic                valid;
    logic [1:0]          prev, cur, dlt;
    logic signed [3:0]   acc, acc_n;
    logic                fwd, rev, bad, up, dn, mv;
    logic [POS_W-1:0]    pos, pos_n;
    logic [FIELD-1:0]    mask;
    logic                stb, err;

    always_comb begin
      a_uni = (&ha) | ~(|ha);
      b_uni = (&hb) | ~(|hb);
      da_n  = (&ha) ? 1'b1 : (~(|ha) ? 1'b0 : da);
      db_n  = (&hb) ? 1'b1 : (~(|hb) ? 1'b0 : db);
      cur   = {da_n, db_n};
      dlt   = gidx(cur) - gidx(prev);
      fwd   = valid && (dlt == 2'd1);
      rev   = valid && (dlt == 2'd3);
      bad   = valid && (dlt == 2'd2);
      acc_n = acc;
      if (fwd) acc_n = acc + 4'sd1;
      if (rev) acc_n = acc - 4'sd1;
      up    = (acc_n == QP);
      dn    = (acc_n == QN);
      mv    = 1'b0;
      pos_n = pos;
`ifdef PADDLE_WRAP_EN
      if (up) begin
        mv    = 1'b1;
        pos_n = (pos == POS_W'(FIELD - 1)) ? '0 : pos + 1'b1;
      end else if (dn) begin
        mv    = 1'b1;
        pos_n = (pos == '0) ? POS_W'(FIELD - 1) : pos - 1'b1;
      end
`else
      if (up && pos != POS_W'(FIELD - PADDLE_LEN)) begin
        mv    = 1'b1;
        pos_n = pos + 1'b1;
      end else if (dn && pos != '0) begin
        mv    = 1'b1;
        pos_n = pos - 1'b1;
      end
`endif
    end

    always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
        sa    <= '0;
        sb    <= '0;
        ha    <= '0;
        hb    <= '0;
        da    <= 1'b0;
        db    <= 1'b0;
        valid <= 1'b0;
        prev  <= '0;
        acc   <= '0;
        pos   <= CTR_P;
        mask  <= mask_of(CTR_P);
        stb   <= 1'b0;
        err   <= 1'b0;
      end else begin
        sa <= {sa[0], quad_a[i]};
        sb <= {sb[0], quad_b[i]};
        ha <= {ha[HIST_LEN-2:0], sa[1]};
        hb <= {hb[HIST_LEN-2:0], sb[1]};
        da <= da_n;
        db <= db_n;
        if (valid) begin
          prev <= cur;
        end else if (a_uni && b_uni) begin
          valid <= 1'b1;
          prev  <= cur;
        end
        if (center) begin
          pos  <= CTR_P;
          mask <= mask_of(CTR_P);
          acc  <= '0;
          err  <= 1'b0;
          stb  <= 1'b0;
        end else begin
          acc <= (up || dn) ? 4'sd0 : acc_n;
          stb <= mv;
          if (bad) err <= 1'b1;
          if (mv) begin
            pos  <= pos_n;
            mask <= mask_of(pos_n);
          end
        end
      end
    end

    assign paddle_pos[i*POS_W +: POS_W]  = pos;
    assign paddle_mask[i*FIELD +: FIELD] = mask;
    assign step_strobe[i]                = stb;
    assign quad_err[i]                   = err;
  end

endmodule

// File: tb/tb_paddle_bank.sv
// Randomised self-checking bench for paddle_bank against a phase-level model.
// Honours PADDLE_WRAP_EN in the model.
module tb_paddle_bank;
  localparam int CH = 2;
  localparam int FL = 32;
  localparam int PL = 8;
  localparam int HL = 4;
  localparam int QS = 4;
  localparam int PW = 5;
  localparam int CTR = (FL - PL) / 2;

  logic             clk = 1'b0;
  logic             reset;
  logic             center;
  logic [CH-1:0]    quad_a, quad_b;
  logic [CH*PW-1:0] paddle_pos;
  logic [CH*FL-1:0] paddle_mask;
  logic [CH-1:0]    step_strobe, quad_err;

  paddle_bank #(
    .CHANNELS(CH), .HIST_LEN(HL), .FIELD(FL),
    .PADDLE_LEN(PL), .QUARTERS_PER_STEP(QS), .POS_W(PW)
  ) dut (
    .clk(clk), .reset(reset), .center(center),
    .quad_a(quad_a), .quad_b(quad_b),
    .paddle_pos(paddle_pos), .paddle_mask(paddle_mask),
    .step_strobe(step_strobe), .quad_err(quad_err)
  );

  always #5 clk = ~clk;

  int n_vec = 0;
  int n_err = 0;
  int m_pos[CH], m_acc[CH], m_stb[CH], s_cnt[CH];
  bit m_err[CH];
  logic [1:0] m_in[CH];
  logic [1:0] gseq[4] = '{2'b00, 2'b01, 2'b11, 2'b10};

  always @(negedge clk)
    for (int c = 0; c < CH; c++)
      if (step_strobe[c]) s_cnt[c]++;

  task automatic check(input string tag,
                       input logic [63:0] obs,
                       input logic [63:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h want %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] mask_exp(input int p);
    logic [63:0] m;
    m = ((64'd1 << PL) - 64'd1) << p;
    return m[31:0] | m[63:32];
  endfunction

  function automatic int gi(input logic [1:0] v);
    int k;
    k = 0;
    for (int j = 0; j < 4; j++)
      if (gseq[j] == v) k = j;
    return k;
  endfunction

  task automatic move(input int c, input int dir);
    int np;
    np = m_pos[c] + dir;
`ifdef PADDLE_WRAP_EN
    m_pos[c] = (np + FL) % FL;
    m_stb[c]++;
`else
    if (np >= 0 && np <= FL - PL) begin
      m_pos[c] = np;
      m_stb[c]++;
    end
`endif
  endtask

  task automatic model_q(input int c, input logic [1:0] nv);
    int d;
    if ((nv ^ m_in[c]) == 2'b11) begin
      m_err[c] = 1'b1;
    end else if (nv != m_in[c]) begin
      d = (gi(nv) - gi(m_in[c]) + 4) % 4;
      m_acc[c] += (d == 1) ? 1 : -1;
      if (m_acc[c] == QS) begin
        m_acc[c] = 0;
        move(c, 1);
      end else if (m_acc[c] == -QS) begin
        m_acc[c] = 0;
        move(c, -1);
      end
    end
    m_in[c] = nv;
  endtask

  task automatic model_reset();
    for (int c = 0; c < CH; c++) begin
      m_pos[c] = CTR;
      m_acc[c] = 0;
      m_err[c] = 1'b0;
      m_in[c]  = 2'b00;
    end
  endtask

  task automatic model_center();
    for (int c = 0; c < CH; c++) begin
      m_pos[c] = CTR;
      m_acc[c] = 0;
      m_err[c] = 1'b0;
    end
  endtask

  task automatic apply(input logic [1:0] n0, input logic [1:0] n1);
    model_q(0, n0);
    model_q(1, n1);
    quad_a = {n1[1], n0[1]};
    quad_b = {n1[0], n0[0]};
    repeat (8) @(negedge clk);
  endtask

  task automatic pulse_center();
    center = 1'b1;
    @(negedge clk);
    center = 1'b0;
    model_center();
    repeat (2) @(negedge clk);
  endtask

  task automatic check_all(input string tag);
    for (int c = 0; c < CH; c++) begin
      check($sformatf("%s pos%0d", tag, c),
            64'(paddle_pos[c*PW +: PW]), 64'(m_pos[c]));
      check($sformatf("%s mask%0d", tag, c),
            64'(paddle_mask[c*FL +: FL]), 64'(mask_exp(m_pos[c])));
      check($sformatf("%s err%0d", tag, c),
            64'(quad_err[c]), 64'(m_err[c]));
      check($sformatf("%s stb%0d", tag, c),
            64'(s_cnt[c]), 64'(m_stb[c]));
    end
  endtask

  function automatic logic [1:0] nxt(input int c, input int dir);
    return gseq[(gi(m_in[c]) + dir + 4) % 4];
  endfunction

  initial begin
    logic [1:0] r[CH];
    int sel;
    for (int c = 0; c < CH; c++) begin
      m_stb[c] = 0;
      s_cnt[c] = 0;
    end
    reset  = 1'b0;
    center = 1'b0;
    quad_a = '0;
    quad_b = '0;
    model_reset();
    repeat (3) @(negedge clk);
    check_all("in_reset");
    reset = 1'b1;
    repeat (10) @(negedge clk);
    check_all("init");
    check("init mask0", 64'(paddle_mask[31:0]), 64'h000FF000);

    apply(2'b01, 2'b00);
    apply(2'b11, 2'b00);
    apply(2'b10, 2'b00);
    apply(2'b00, 2'b00);
    check_all("detent");
    check("detent pos0", 64'(paddle_pos[4:0]), 64'd13);
    check("detent mask0", 64'(paddle_mask[31:0]), 64'h001FE000);

    for (int k = 0; k < 7; k++) begin
      quad_a[0] = k[0] ? 1'b0 : 1'b1;
      quad_b[0] = k[0] ? 1'b0 : 1'b1;
      @(negedge clk);
    end
    quad_a[0] = 1'b0;
    quad_b[0] = 1'b0;
    repeat (10) @(negedge clk);
    check_all("chatter");

    for (int d = 1; d <= 14; d++) begin
      for (int q = 0; q < 4; q++) apply(m_in[0], nxt(1, -1));
      check_all($sformatf("rev%0d", d));
      if (d == 12)
        check("rev12 pos1", 64'(paddle_pos[9:5]), 64'd0);
    end
`ifdef PADDLE_WRAP_EN
    check("rev14 pos1", 64'(paddle_pos[9:5]), 64'd30);
    check("rev14 mask1", 64'(paddle_mask[63:32]), 64'hC000003F);
`else
    check("rev14 pos1", 64'(paddle_pos[9:5]), 64'd0);
`endif

    apply(2'b11, m_in[1]);
    check_all("jump");
    check("jump err0", 64'(quad_err[0]), 64'd1);
    repeat (8) @(negedge clk);
    check("err sticky", 64'(quad_err[0]), 64'd1);
    pulse_center();
    check_all("center");
    check("center pos0", 64'(paddle_pos[4:0]), 64'd12);
    check("center err", 64'(quad_err), 64'd0);

    for (int t = 0; t < 40; t++) begin
      for (int c = 0; c < CH; c++) begin
        sel = int'($urandom_range(0, 15));
        if (sel < 6)       r[c] = nxt(c, 1);
        else if (sel < 12) r[c] = nxt(c, -1);
        else if (sel < 14) r[c] = m_in[c];
        else               r[c] = nxt(c, 2);
      end
      apply(r[0], r[1]);
      if ($urandom_range(0, 9) == 0) pulse_center();
      check_all($sformatf("rnd%0d", t));
    end

    pulse_center();
    apply(nxt(0, 1), m_in[1]);
    apply(nxt(0, 1), m_in[1]);
    reset = 1'b0;
    model_reset();
    #1;
    check_all("mid_reset");
    quad_a = '0;
    quad_b = '0;
    repeat (3) @(negedge clk);
    reset = 1'b1;
    repeat (10) @(negedge clk);
    for (int q = 0; q < 4; q++) apply(nxt(0, 1), 2'b00);
    check_all("post_reset");
    check("post_reset pos0", 64'(paddle_pos[4:0]), 64'd13);
    check("post_reset pos1", 64'(paddle_pos[9:5]), 64'd12);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
